// File: rtl/jfpjc_dct_readout_arbiter_if.sv
// ============================================================================
// Module   : jfpjc_dct_readout_arbiter_if
// Purpose  : Request/release, shared memory read and coefficient stream
//            signals between the DCT engines and the readout arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface jfpjc_dct_readout_arbiter_if #(
  parameter int NUM_DCTS   = 5,
  parameter int COEF_WIDTH = 16,
  parameter int SEL_WIDTH  = 3
);
  logic [NUM_DCTS-1:0]            blk_ready;
  logic [NUM_DCTS-1:0]            blk_done;
  logic [5:0]                     mem_addr;
  logic [SEL_WIDTH-1:0]           mem_sel;
  logic [NUM_DCTS*COEF_WIDTH-1:0] mem_rdata;
  logic [COEF_WIDTH-1:0]          out_data;
  logic [5:0]                     out_idx;
  logic [SEL_WIDTH-1:0]           out_src;
  logic                           out_last;
  logic                           out_valid;
  logic                           out_ready;

  modport master (
    input  blk_ready, mem_rdata, out_ready,
    output blk_done, mem_addr, mem_sel,
    output out_data, out_idx, out_src, out_last, out_valid
  );

  modport slave (
    output blk_ready, mem_rdata, out_ready,
    input  blk_done, mem_addr, mem_sel,
    input  out_data, out_idx, out_src, out_last, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/jfpjc_dct_readout_arbiter.sv
// ============================================================================
// Module   : jfpjc_dct_readout_arbiter
// Purpose  : Round-robin readout of finished 8x8 DCT blocks into one
//            valid/ready coefficient stream through a 2-entry output FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module jfpjc_dct_readout_arbiter #(
  parameter int NUM_DCTS   = 5,
  parameter int COEF_WIDTH = 16,
  parameter int SEL_WIDTH  = 3
) (
  input wire clock,
  input wire nreset,
  jfpjc_dct_readout_arbiter_if.master bus
);

  localparam logic [5:0] c_last_addr = 6'd63;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [SEL_WIDTH-1:0]  r_rr;
  logic [SEL_WIDTH-1:0]  r_cur;
  logic [5:0]            r_addr;
  logic                  r_if_valid;
  logic [5:0]            r_if_idx;
  logic [SEL_WIDTH-1:0]  r_if_src;

  logic [COEF_WIDTH-1:0] r_fifo_data [2];
  logic [5:0]            r_fifo_idx  [2];
  logic [SEL_WIDTH-1:0]  r_fifo_src  [2];
  logic                  r_fifo_last [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_found;
  logic [SEL_WIDTH-1:0]  w_pick;
  logic [SEL_WIDTH:0]    w_sum;
  logic                  w_pop;
  logic [2:0]            w_level;
  logic                  w_select;
  logic                  w_issue;
  logic                  w_block_end;
  logic [COEF_WIDTH-1:0] w_slice [NUM_DCTS];

  for (genvar g = 0; g < NUM_DCTS; g++) begin : g_slice
    assign w_slice[g] = bus.mem_rdata[g*COEF_WIDTH +: COEF_WIDTH];
  end

  // First requester at or after the round-robin pointer, modulo NUM_DCTS.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_DCTS; k++) begin
      w_sum = {1'b0, r_rr} + (SEL_WIDTH+1)'(k);
      if (w_sum >= (SEL_WIDTH+1)'(NUM_DCTS)) begin
        w_sum = w_sum - (SEL_WIDTH+1)'(NUM_DCTS);
      end
      if (!w_found && bus.blk_ready[w_sum[SEL_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[SEL_WIDTH-1:0];
      end
    end
  end

  // A pop in this cycle frees a slot, which keeps one beat per cycle flowing.
  assign w_pop   = (r_count != 2'd0) && bus.out_ready;
  assign w_level = {1'b0, r_count} + {2'b00, r_if_valid} - {2'b00, w_pop};

  always_comb begin
    w_state_next = r_state;
    w_select     = 1'b0;
    w_issue      = 1'b0;
    w_block_end  = 1'b0;
    bus.blk_done = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_select     = 1'b1;
          w_state_next = ST_READ;
        end
      end
      ST_READ: begin
        if (w_level < 3'd2) begin
          w_issue = 1'b1;
          if (r_addr == c_last_addr) begin
            w_block_end         = 1'b1;
            bus.blk_done[r_cur] = 1'b1;
            w_state_next        = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_rr       <= '0;
      r_cur      <= '0;
      r_addr     <= '0;
      r_if_valid <= 1'b0;
      r_if_idx   <= '0;
      r_if_src   <= '0;
    end else begin
      r_if_valid <= w_issue;
      if (w_issue) begin
        r_if_idx <= r_addr;
        r_if_src <= r_cur;
        r_addr   <= r_addr + 6'd1;
      end
      if (w_select) begin
        r_cur  <= w_pick;
        r_addr <= '0;
      end
      if (w_block_end) begin
        r_rr <= (r_cur == SEL_WIDTH'(NUM_DCTS-1)) ? '0 : r_cur + SEL_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      for (int e = 0; e < 2; e++) begin
        r_fifo_data[e] <= '0;
        r_fifo_idx[e]  <= '0;
        r_fifo_src[e]  <= '0;
        r_fifo_last[e] <= 1'b0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (r_if_valid) begin
        r_fifo_data[r_wr_ptr] <= w_slice[r_if_src];
        r_fifo_idx[r_wr_ptr]  <= r_if_idx;
        r_fifo_src[r_wr_ptr]  <= r_if_src;
        r_fifo_last[r_wr_ptr] <= (r_if_idx == c_last_addr);
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_if_valid} - {1'b0, w_pop};
    end
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_sel   = r_cur;
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_data  = r_fifo_data[r_rd_ptr];
  assign bus.out_idx   = r_fifo_idx[r_rd_ptr];
  assign bus.out_src   = r_fifo_src[r_rd_ptr];
  assign bus.out_last  = r_fifo_last[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_jfpjc_dct_readout_arbiter.sv
// ============================================================================
// Module   : tb_jfpjc_dct_readout_arbiter
// Purpose  : Directed self-checking bench for the DCT readout arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_jfpjc_dct_readout_arbiter;

  localparam int NUM_DCTS   = 5;
  localparam int COEF_WIDTH = 16;
  localparam int SEL_WIDTH  = 3;

  logic clock = 1'b0;
  logic nreset;

  always #5 clock = ~clock;

  jfpjc_dct_readout_arbiter_if #(
    .NUM_DCTS(NUM_DCTS), .COEF_WIDTH(COEF_WIDTH), .SEL_WIDTH(SEL_WIDTH)
  ) bus ();

  jfpjc_dct_readout_arbiter #(
    .NUM_DCTS(NUM_DCTS), .COEF_WIDTH(COEF_WIDTH), .SEL_WIDTH(SEL_WIDTH)
  ) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus.master)
  );

  function automatic logic [15:0] coef(input int s, input int a);
    logic [31:0] t;
    t = 32'(s * 4099 + a * 37 + 11);
    return t[15:0];
  endfunction

  // Every engine memory sees the shared address; synchronous read.
  logic [NUM_DCTS*COEF_WIDTH-1:0] rdata_next;
  always_comb begin
    rdata_next = '0;
    for (int i = 0; i < NUM_DCTS; i++) begin
      rdata_next[i*COEF_WIDTH +: COEF_WIDTH] = coef(i, int'(bus.mem_addr));
    end
  end
  always @(posedge clock) bus.mem_rdata <= rdata_next;

  int          n_checks;
  int          n_errors;
  int          exp_src_q[$];
  int          exp_done_q[$];
  int          exp_idx;
  bit          held;
  logic [26:0] prev_bundle;
  int          cyc;
  int          first_valid_cyc;
  int          last_beat_cyc;
  int          t_start;
  int          stall_pct;
  bit          clear_on_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] bundle();
    return {bus.out_data, bus.out_idx, bus.out_src, bus.out_last, bus.out_valid};
  endfunction

  task automatic tick();
    @(negedge clock);
    cyc++;
    bus.out_ready = (int'($urandom_range(0, 99)) >= stall_pct);
    #1;
    if (held) check("hold_stable", 32'(bundle()), 32'(prev_bundle));
    if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bus.out_valid && bus.out_ready) begin
      check("beat_expected", 32'(exp_src_q.size() != 0), 32'd1);
      if (exp_src_q.size() != 0) begin
        check("out_src",  32'(bus.out_src),  32'(exp_src_q[0]));
        check("out_idx",  32'(bus.out_idx),  32'(exp_idx));
        check("out_data", 32'(bus.out_data), 32'(coef(exp_src_q[0], exp_idx)));
        check("out_last", 32'(bus.out_last), 32'(exp_idx == 63));
        exp_idx++;
        if (exp_idx == 64) begin
          exp_idx = 0;
          void'(exp_src_q.pop_front());
        end
      end
      last_beat_cyc = cyc;
    end
    held        = bus.out_valid && !bus.out_ready;
    prev_bundle = bundle();
    if (bus.blk_done != '0) begin
      check("done_expected", 32'(exp_done_q.size() != 0), 32'd1);
      if (exp_done_q.size() != 0) begin
        check("blk_done", 32'(bus.blk_done), 32'(1 << exp_done_q.pop_front()));
      end
      if (clear_on_done) bus.blk_ready = bus.blk_ready & ~bus.blk_done;
    end
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((exp_src_q.size() != 0 || exp_done_q.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    if (n >= max_cycles) check("drain_timeout", 32'(exp_src_q.size() + exp_done_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    held   = 1'b0;
    nreset = 1'b0;
    repeat (cycles) tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_blk_done",  32'(bus.blk_done),  32'd0);
    check("rst_out_idx",   32'(bus.out_idx),   32'd0);
    check("rst_out_src",   32'(bus.out_src),   32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_mem_sel",   32'(bus.mem_sel),   32'd0);
    nreset = 1'b1;
    exp_src_q.delete();
    exp_done_q.delete();
    exp_idx = 0;
  endtask

  task automatic wait_idx(input int target);
    int n;
    n = 0;
    while (exp_idx < target && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check("wait_idx_timeout", 32'(exp_idx), 32'(target));
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    exp_idx         = 0;
    held            = 1'b0;
    prev_bundle     = '0;
    cyc             = 0;
    first_valid_cyc = -1;
    last_beat_cyc   = 0;
    stall_pct       = 0;
    clear_on_done   = 1'b1;
    nreset          = 1'b0;
    bus.blk_ready   = '0;
    bus.out_ready   = 1'b1;

    do_reset(3);

    // Single block from DCT2; first beat three cycles after the request.
    tick();
    first_valid_cyc = -1;
    t_start         = cyc;
    bus.blk_ready   = 5'b00100;
    exp_src_q       = {2};
    exp_done_q      = {2};
    drain(200);
    check("t1_latency", 32'(first_valid_cyc - t_start), 32'd3);
    repeat (4) tick();
    check("t1_idle_after", 32'(bus.out_valid), 32'd0);

    // Pointer is now 3: DCT0 wraps ahead of DCT1, then search resumes at 2.
    bus.blk_ready = 5'b00011;
    exp_src_q     = {0, 1};
    exp_done_q    = {0, 1};
    drain(400);
    bus.blk_ready = 5'b10001;
    exp_src_q     = {4, 0};
    exp_done_q    = {4, 0};
    drain(400);

    // All five requesting from a fresh pointer: 5x64 beats, 1 bubble between.
    do_reset(2);
    tick();
    first_valid_cyc = -1;
    bus.blk_ready   = 5'b11111;
    exp_src_q       = {0, 1, 2, 3, 4};
    exp_done_q      = {0, 1, 2, 3, 4};
    drain(600);
    check("t2_span", 32'(last_beat_cyc - first_valid_cyc + 1), 32'd324);

    // Two blocks under 30% random backpressure.
    stall_pct     = 30;
    bus.blk_ready = 5'b00101;
    exp_src_q     = {0, 2};
    exp_done_q    = {0, 2};
    drain(2000);
    stall_pct = 0;
    tick();

    // Reset in the middle of DCT1; it is re-read from 0 and pointer is back at 0.
    bus.blk_ready = 5'b00010;
    exp_src_q     = {1};
    exp_done_q    = {1};
    wait_idx(21);
    do_reset(1);
    bus.blk_ready = 5'b01010;
    exp_src_q     = {1, 3};
    exp_done_q    = {1, 3};
    drain(400);

    // Request withdrawn mid-block: the block still completes.
    clear_on_done = 1'b0;
    bus.blk_ready = 5'b10000;
    exp_src_q     = {4};
    exp_done_q    = {4};
    wait_idx(11);
    bus.blk_ready = '0;
    drain(200);
    repeat (5) tick();
    check("t6_idle_after", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1);
  end

endmodule

`default_nettype wire
